// File: rtl/mux_stream_arbiter.sv
// Two-source round-robin arbiter driving the select of a shared 2:1 stream mux.
// Grants are held for a whole packet and handed over without a bubble on the last beat.
module mux_stream_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  input  logic             y_ready,
  output logic             sel,
  output logic             gnt_a,
  output logic             gnt_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   prio_q, prio_d;

  logic a_owner;
  logic b_owner;
  logic a_end;
  logic b_end;

  assign a_owner = (state_q == GRANT_A);
  assign b_owner = (state_q == GRANT_B);

  assign y_data  = sel_q ? b_data : a_data;
  assign y_last  = sel_q ? b_last : a_last;
  assign y_valid = (a_owner & a_valid) | (b_owner & b_valid);
  assign a_ready = a_owner & y_ready;
  assign b_ready = b_owner & y_ready;

  assign sel   = sel_q;
  assign gnt_a = a_owner;
  assign gnt_b = b_owner;

  // A packet ends only on an accepted beat carrying last from the current owner.
  assign a_end = a_owner & a_valid & y_ready & a_last;
  assign b_end = b_owner & b_valid & y_ready & b_last;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (a_valid && (!b_valid || !prio_q)) begin
          state_d = GRANT_A;
          sel_d   = 1'b0;
        end else if (b_valid) begin
          state_d = GRANT_B;
          sel_d   = 1'b1;
        end
      end
      GRANT_A: begin
        if (a_end) begin
          prio_d = 1'b1;
          if (b_valid) begin
            state_d = GRANT_B;
            sel_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GRANT_B: begin
        if (b_end) begin
          prio_d = 1'b0;
          if (a_valid) begin
            state_d = GRANT_A;
            sel_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

endmodule
